// File: rtl/writeback_stage_if.sv
// Upstream handshake and memory read-response bundle feeding the writeback stage.
interface writeback_stage_if #(
  parameter int DWIDTH = 32
);
  logic              ex_valid;
  logic              ex_ready;
  logic [4:0]        ex_rd;
  logic [1:0]        ex_wbsel;
  logic [DWIDTH-1:0] ex_alu;
  logic [DWIDTH-1:0] ex_pc;
  logic [2:0]        ex_funct3;
  logic [1:0]        ex_addr_lo;
  logic              mem_rvalid;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    output ex_valid, ex_rd, ex_wbsel, ex_alu, ex_pc, ex_funct3, ex_addr_lo,
    output mem_rvalid, mem_rdata,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_wbsel, ex_alu, ex_pc, ex_funct3, ex_addr_lo,
    input  mem_rvalid, mem_rdata,
    output ex_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: selects ALU / PC+4 / extended load data for the register file,
// counts retired instructions and aborts loads whose memory response never arrives.
module writeback_stage #(
  parameter int DWIDTH      = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_stage_if.slave     pipe_io,
  output logic [4:0]           rd_o,
  output logic [DWIDTH-1:0]    datawb_o,
  output logic                 regwren_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o,
  output logic                 err_o
);

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT_MEM} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             ldRd_q, ldRd_d;
  logic [2:0]             ldFunct3_q, ldFunct3_d;
  logic [1:0]             ldAddrLo_q, ldAddrLo_d;
  logic [TW-1:0]          tmoCnt_q, tmoCnt_d;
  logic                   pendValid_q, pendValid_d;
  logic [4:0]             pendRd_q, pendRd_d;
  logic [DWIDTH-1:0]      pendData_q, pendData_d;
  logic                   pendWr_q, pendWr_d;
  logic [4:0]             rd_q, rd_d;
  logic [DWIDTH-1:0]      datawb_q, datawb_d;
  logic                   regwren_q, regwren_d;
  logic [CNT_WIDTH-1:0]   retireCnt_q, retireCnt_d;
  logic                   err_q, err_d;

  logic                   exReady, accept, isLoad, loadDone;
  logic [DWIDTH-1:0]      directData;
  logic                   directWr;
  logic                   cmpValid, cmpWr;
  logic [4:0]             cmpRd;
  logic [DWIDTH-1:0]      cmpData;

  function automatic logic [DWIDTH-1:0] extendLoad(input logic [2:0]        f3,
                                                   input logic [1:0]        lo,
                                                   input logic [DWIDTH-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    extendLoad = DWIDTH'($signed(b));
      3'd4:    extendLoad = DWIDTH'(b);
      3'd1:    extendLoad = DWIDTH'($signed(h));
      3'd5:    extendLoad = DWIDTH'(h);
      default: extendLoad = w;
    endcase
  endfunction

  assign pipe_io.ex_ready = exReady;
  assign rd_o             = rd_q;
  assign datawb_o         = datawb_q;
  assign regwren_o        = regwren_q;
  assign retire_cnt_o     = retireCnt_q;
  assign err_o            = err_q;

  // A non-load accepted while a load or a held result is retiring waits one slot in
  // the pending register so that every completion still gets its own write cycle.
  always_comb begin
    state_d     = state_q;
    ldRd_d      = ldRd_q;
    ldFunct3_d  = ldFunct3_q;
    ldAddrLo_d  = ldAddrLo_q;
    tmoCnt_d    = tmoCnt_q;
    pendValid_d = 1'b0;
    pendRd_d    = pendRd_q;
    pendData_d  = pendData_q;
    pendWr_d    = pendWr_q;
    rd_d        = rd_q;
    datawb_d    = datawb_q;
    regwren_d   = 1'b0;
    retireCnt_d = retireCnt_q;
    err_d       = err_q;
    cmpValid    = 1'b0;
    cmpWr       = 1'b0;
    cmpRd       = 5'd0;
    cmpData     = '0;

    exReady  = (state_q == IDLE) || ((state_q == WAIT_MEM) && pipe_io.mem_rvalid);
    accept   = pipe_io.ex_valid && exReady;
    isLoad   = (pipe_io.ex_wbsel == 2'd1);
    loadDone = (state_q == WAIT_MEM) && pipe_io.mem_rvalid;

    case (pipe_io.ex_wbsel)
      2'd0:    directData = pipe_io.ex_alu;
      2'd2:    directData = pipe_io.ex_pc + DWIDTH'(4);
      default: directData = '0;
    endcase
    directWr = (pipe_io.ex_wbsel != 2'd3);

    if (loadDone) begin
      cmpValid = 1'b1;
      cmpWr    = 1'b1;
      cmpRd    = ldRd_q;
      cmpData  = extendLoad(ldFunct3_q, ldAddrLo_q, pipe_io.mem_rdata);
    end else if (pendValid_q) begin
      cmpValid = 1'b1;
      cmpWr    = pendWr_q;
      cmpRd    = pendRd_q;
      cmpData  = pendData_q;
    end else if (accept && !isLoad) begin
      cmpValid = 1'b1;
      cmpWr    = directWr;
      cmpRd    = pipe_io.ex_rd;
      cmpData  = directData;
    end

    if (accept && !isLoad && (loadDone || pendValid_q)) begin
      pendValid_d = 1'b1;
      pendRd_d    = pipe_io.ex_rd;
      pendData_d  = directData;
      pendWr_d    = directWr;
    end

    if (cmpValid) begin
      rd_d        = cmpRd;
      regwren_d   = cmpWr && (cmpRd != 5'd0);
      datawb_d    = regwren_d ? cmpData : '0;
      retireCnt_d = retireCnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (accept && isLoad) begin
          state_d    = WAIT_MEM;
          ldRd_d     = pipe_io.ex_rd;
          ldFunct3_d = pipe_io.ex_funct3;
          ldAddrLo_d = pipe_io.ex_addr_lo;
          tmoCnt_d   = '0;
        end
      end
      WAIT_MEM: begin
        if (pipe_io.mem_rvalid) begin
          if (accept && isLoad) begin
            ldRd_d     = pipe_io.ex_rd;
            ldFunct3_d = pipe_io.ex_funct3;
            ldAddrLo_d = pipe_io.ex_addr_lo;
            tmoCnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (tmoCnt_q == TW'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ldRd_q      <= '0;
      ldFunct3_q  <= '0;
      ldAddrLo_q  <= '0;
      tmoCnt_q    <= '0;
      pendValid_q <= 1'b0;
      pendRd_q    <= '0;
      pendData_q  <= '0;
      pendWr_q    <= 1'b0;
      rd_q        <= '0;
      datawb_q    <= '0;
      regwren_q   <= 1'b0;
      retireCnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ldRd_q      <= ldRd_d;
      ldFunct3_q  <= ldFunct3_d;
      ldAddrLo_q  <= ldAddrLo_d;
      tmoCnt_q    <= tmoCnt_d;
      pendValid_q <= pendValid_d;
      pendRd_q    <= pendRd_d;
      pendData_q  <= pendData_d;
      pendWr_q    <= pendWr_d;
      rd_q        <= rd_d;
      datawb_q    <= datawb_d;
      regwren_q   <= regwren_d;
      retireCnt_q <= retireCnt_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: stimulus pushes expected writebacks into a queue,
// a negedge monitor pops one entry whenever the retire counter advances.
module tb_writeback_stage;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    rd_o;
  logic [DW-1:0] datawb_o;
  logic          regwren_o;
  logic [31:0]   retire_cnt_o;
  logic          err_o;

  writeback_stage_if #(.DWIDTH(DW)) bus();

  writeback_stage #(.DWIDTH(DW), .MEM_TIMEOUT(TMO), .CNT_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_io      (bus),
    .rd_o         (rd_o),
    .datawb_o     (datawb_o),
    .regwren_o    (regwren_o),
    .retire_cnt_o (retire_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wren;
  } exp_t;

  exp_t expQ[$];
  int   checksTotal  = 0;
  int   checksPassed = 0;
  int   lastCnt      = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic pushExpect(input logic [4:0] rd, input logic [31:0] data, input logic wren);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    e.wren = wren;
    expQ.push_back(e);
  endtask

  // Monitor: one scoreboard entry per retire-counter step.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      lastCnt = 0;
    end else if (retire_cnt_o != 32'(lastCnt)) begin
      checkOutput("retire_step", retire_cnt_o, 32'(lastCnt + 1));
      checkOutput("scoreboard_has_entry", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("wb_rd", 32'(rd_o), 32'(e.rd));
        checkOutput("wb_data", datawb_o, e.data);
        checkOutput("wb_wren", 32'(regwren_o), 32'(e.wren));
      end
      lastCnt = int'(retire_cnt_o);
    end else if (regwren_o) begin
      checkOutput("spurious_wren", 32'(regwren_o), 32'd0);
    end
  end

  // Presents one instruction (called at posedge+1) and returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic [4:0] rd, input logic [1:0] wbsel, input logic [31:0] alu,
                               input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] lo);
    bit ok = 1'b0;
    bus.ex_valid   = 1'b1;
    bus.ex_rd      = rd;
    bus.ex_wbsel   = wbsel;
    bus.ex_alu     = alu;
    bus.ex_pc      = pc;
    bus.ex_funct3  = f3;
    bus.ex_addr_lo = lo;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ok = bus.ex_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    bus.ex_valid = 1'b0;
    checkOutput("accepted", 32'(ok), 32'd1);
  endtask

  task automatic memRespond(input int idle, input logic [31:0] data);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      checkOutput("ready_low_wait", 32'(bus.ex_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    @(negedge clk);
    checkOutput("ready_on_rvalid", 32'(bus.ex_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic doLoad(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] data, input int idle, input logic [31:0] expData);
    pushExpect(rd, (rd == 5'd0) ? 32'd0 : expData, rd != 5'd0);
    applyStimulus(rd, 2'd1, 32'd0, 32'd0, f3, lo);
    memRespond(idle, data);
  endtask

  initial begin
    logic [31:0] cntSnap;
    bus.ex_valid   = 1'b0;
    bus.ex_rd      = '0;
    bus.ex_wbsel   = '0;
    bus.ex_alu     = '0;
    bus.ex_pc      = '0;
    bus.ex_funct3  = '0;
    bus.ex_addr_lo = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_rd", 32'(rd_o), 32'd0);
    checkOutput("rst_data", datawb_o, 32'd0);
    checkOutput("rst_wren", 32'(regwren_o), 32'd0);
    checkOutput("rst_retire", retire_cnt_o, 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ALU result, one-cycle write pulse
    pushExpect(5'd5, 32'h0000_1234, 1'b1);
    applyStimulus(5'd5, 2'd0, 32'h0000_1234, 32'h0, 3'd0, 2'd0);
    @(negedge clk);
    checkOutput("alu_wren_t1", 32'(regwren_o), 32'd1);
    @(negedge clk);
    checkOutput("alu_wren_t2", 32'(regwren_o), 32'd0);
    checkOutput("alu_retire_t2", retire_cnt_o, 32'd1);
    @(posedge clk);
    #1;

    pushExpect(5'd1, 32'h0000_0104, 1'b1);
    applyStimulus(5'd1, 2'd2, 32'h0, 32'h0000_0100, 3'd0, 2'd0);
    pushExpect(5'd7, 32'h0, 1'b0);
    applyStimulus(5'd7, 2'd3, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0);
    pushExpect(5'd0, 32'h0, 1'b0);
    applyStimulus(5'd0, 2'd0, 32'h0000_0055, 32'h0, 3'd0, 2'd0);

    doLoad(5'd3, 3'd0, 2'd3, 32'h80FF_0000, 3, 32'hFFFF_FF80);
    doLoad(5'd4, 3'd4, 2'd3, 32'h80FF_0000, 1, 32'h0000_0080);
    doLoad(5'd0, 3'd1, 2'd2, 32'h8001_7FFF, 2, 32'hFFFF_8001);
    doLoad(5'd6, 3'd1, 2'd3, 32'h8001_7FFF, 0, 32'hFFFF_8001);
    doLoad(5'd8, 3'd5, 2'd0, 32'h8001_7FFF, 1, 32'h0000_7FFF);
    doLoad(5'd2, 3'd0, 2'd1, 32'h8001_7FFF, 1, 32'h0000_007F);
    doLoad(5'd9, 3'd3, 2'd2, 32'h1357_9BDF, 1, 32'h1357_9BDF);

    // LW completes while an ALU op is accepted, followed straight by another ALU op
    pushExpect(5'd10, 32'hCAFE_BABE, 1'b1);
    applyStimulus(5'd10, 2'd1, 32'h0, 32'h0, 3'd2, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_BABE;
    bus.ex_valid   = 1'b1;
    bus.ex_rd      = 5'd11;
    bus.ex_wbsel   = 2'd0;
    bus.ex_alu     = 32'h0000_0077;
    pushExpect(5'd11, 32'h0000_0077, 1'b1);
    @(negedge clk);
    checkOutput("b2b_ready", 32'(bus.ex_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    bus.ex_rd      = 5'd12;
    bus.ex_alu     = 32'h0000_0099;
    pushExpect(5'd12, 32'h0000_0099, 1'b1);
    @(negedge clk);
    checkOutput("b2b_ready_idle", 32'(bus.ex_ready), 32'd1);
    checkOutput("b2b_first_wren", 32'(regwren_o), 32'd1);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_second_wren", 32'(regwren_o), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back loads
    pushExpect(5'd13, 32'h1234_5678, 1'b1);
    applyStimulus(5'd13, 2'd1, 32'h0, 32'h0, 3'd2, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    bus.ex_valid   = 1'b1;
    bus.ex_rd      = 5'd14;
    bus.ex_wbsel   = 2'd1;
    bus.ex_funct3  = 3'd4;
    bus.ex_addr_lo = 2'd1;
    pushExpect(5'd14, 32'h0000_00AB, 1'b1);
    @(negedge clk);
    checkOutput("ld2_ready", 32'(bus.ex_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.ex_valid   = 1'b0;
    bus.mem_rvalid = 1'b0;
    memRespond(1, 32'h0000_AB00);
    repeat (3) @(posedge clk);
    #1;

    // Load with no response: aborts after TMO cycles in WAIT_MEM
    cntSnap = retire_cnt_o;
    applyStimulus(5'd15, 2'd1, 32'h0, 32'h0, 3'd2, 2'd0);
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      checkOutput("tmo_err_pending", 32'(err_o), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("tmo_err_set", 32'(err_o), 32'd1);
    checkOutput("tmo_ready_idle", 32'(bus.ex_ready), 32'd1);
    checkOutput("tmo_no_retire", retire_cnt_o, cntSnap);
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("idle_rvalid_ignored", retire_cnt_o, cntSnap);
    checkOutput("err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of WAIT_MEM
    @(posedge clk);
    #1;
    applyStimulus(5'd16, 2'd1, 32'h0, 32'h0, 3'd2, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_rd", 32'(rd_o), 32'd0);
    checkOutput("mid_rst_data", datawb_o, 32'd0);
    checkOutput("mid_rst_wren", 32'(regwren_o), 32'd0);
    checkOutput("mid_rst_retire", retire_cnt_o, 32'd0);
    checkOutput("mid_rst_err", 32'(err_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_no_write", retire_cnt_o, 32'd0);
    checkOutput("post_rst_ready", 32'(bus.ex_ready), 32'd1);
    @(posedge clk);
    #1;
    pushExpect(5'd17, 32'h0000_0ABC, 1'b1);
    applyStimulus(5'd17, 2'd0, 32'h0000_0ABC, 32'h0, 3'd0, 2'd0);

    for (int i = 0; i < 50; i++) begin
      if (expQ.size() == 0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("final_retire", retire_cnt_o, 32'd1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
